// File: rtl/sdf_sram_delay_line_pkg.sv
// Shared defaults for the SDF stage delay memory.
// Also holds the DEPTH legality check used at elaboration.
package sdf_sram_delay_line_pkg;

    localparam int SDF_DATA_W = 32;
    localparam int SDF_ADDR_W = 8;
    localparam int SDF_DEPTH  = 256;

    function automatic bit depth_ok(input int depth, input int addr_w);
        return (depth >= 2) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/sdf_sram_delay_line_fifo.sv
// Two-entry registered output FIFO for the SDF delay line.
// Push and pop in the same cycle are both honoured.
module sdf_skid_fifo2
    import sdf_sram_delay_line_pkg::*;
#(
    parameter int DATA_W = SDF_DATA_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (do_push) begin
                buf_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = buf_q[rd_ptr_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/sdf_sram_delay_line.sv
// Streaming DEPTH-sample delay line over a 1R1W SRAM (1-cycle read).
// Feeds the feedback path of an SDF radix-2^2 FFT stage.
module sdf_sram_delay_line
    import sdf_sram_delay_line_pkg::*;
#(
    parameter int DATA_W = SDF_DATA_W,
    parameter int ADDR_W = SDF_ADDR_W,
    parameter int DEPTH  = SDF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              primed,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data
);

    localparam int FILL_W = $clog2(DEPTH + 1);

    if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
        $error("sdf_sram_delay_line: DEPTH out of range for ADDR_W");
    end

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [1:0]        occ;
    logic              push;
    logic              pop;

    // Outstanding read counts against FIFO space so a capture never overflows.
    assign in_ready = !reset && !clear
                   && (({1'b0, occ} + {2'b00, rd_pend_q}) < 3'd2);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign primed   = (fill_q == FILL_W'(DEPTH));

    always_comb begin
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        rd_pend_d = 1'b0;
        wr_pend_d = push;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (push) begin
            wr_addr_d = ptr_q;
            wr_data_d = in_data;
            rd_pend_d = primed;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
            if (!primed) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
        if (clear) begin
            ptr_d     = '0;
            fill_d    = '0;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            fill_q    <= '0;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mem_r_en   = push;
    assign mem_r_addr = ptr_q;
    assign mem_w_en   = wr_pend_q;
    assign mem_w_addr = wr_addr_q;
    assign mem_w_data = wr_data_q;

    sdf_skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_out_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .clear_i (clear),
        .push_i  (rd_pend_q),
        .data_i  (mem_r_data),
        .pop_i   (pop),
        .valid_o (out_valid),
        .data_o  (out_data),
        .occ_o   (occ)
    );

endmodule
